// File: rtl/vid_fetch_arbiter.sv
// vid_fetch_arbiter
// Shares one byte-wide memory port between the scanline fetch engine and a
// host port. A fetch reads LINE_BYTES consecutive bytes from line_base into
// the line buffer. One issue slot in every HOST_PERIOD fetch cycles goes to a
// pending host operation. When the fetch is idle or draining, a host
// operation is issued as soon as it is seen. Memory reads return data two
// cycles after issue. A two-stage tag pipeline sends each returning byte
// either to the line buffer or to the host.
module vid_fetch_arbiter #(
    parameter int LINE_BYTES  = 160,
    parameter int HOST_PERIOD = 4
) (
    input  logic        clk_vid,
    input  logic        reset,
    input  logic        line_start,
    input  logic [16:0] line_base,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [16:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic [16:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        lb_we,
    output logic [7:0]  lb_addr,
    output logic [7:0]  lb_data,
    output logic        fetch_busy,
    output logic        overrun
);

    localparam logic [7:0] LAST_IDX  = 8'(LINE_BYTES - 1);
    localparam logic [2:0] SLOT_LAST = 3'(HOST_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One entry of the read-return pipeline.
    typedef struct packed {
        logic       valid;  // a read occupies this stage
        logic       host;   // 1 = host read, 0 = fetch read
        logic [7:0] idx;    // line-buffer index of a fetch read
    } tag_t;

    state_t      state;
    state_t      state_next;

    logic [16:0] base_q;         // line_base latched at line_start
    logic [7:0]  idx_q;          // next fetch index to issue
    logic [2:0]  slot_q;         // host-slot counter, runs only in FETCH
    logic        host_issued_q;  // host op issued, its host_ack still to come
    logic        wr_ack_q;       // host write issued last cycle
    logic        overrun_q;

    tag_t        tag1_q;         // issued one cycle ago
    tag_t        tag2_q;         // issued two cycles ago, data on mem_rdata now
    tag_t        tag1_d;
    tag_t        tag2_d;

    logic        host_pending;
    logic        host_slot;
    logic        issue_fetch;
    logic        issue_host;
    logic        restart;
    logic        rd_ack;
    logic        host_ack_raw;
    logic        fetch_inflight;
    logic [16:0] fetch_addr;

    // A held request counts as new only after its host_ack cycle has passed.
    assign host_pending   = host_req && !host_issued_q;
    assign host_slot      = (slot_q == SLOT_LAST) && host_pending;
    // The 17-bit sum wraps the fetch address modulo 2^17.
    assign fetch_addr     = base_q + {9'd0, idx_q};
    assign rd_ack         = tag2_q.valid && tag2_q.host;
    assign host_ack_raw   = wr_ack_q || rd_ack;
    // The entry in stage 2 returns this cycle, so only stage 1 keeps DRAIN busy.
    assign fetch_inflight = tag1_q.valid && !tag1_q.host;
    assign overrun        = overrun_q;

    // Next-state logic and the one-operation-per-cycle issue decision.
    always_comb begin
        // NOTE: every signal gets a default before the case, so no path can leave one unassigned and infer a latch.
        state_next  = state;
        issue_fetch = 1'b0;
        issue_host  = 1'b0;
        restart     = 1'b0;

        case (state)
            IDLE: begin
                issue_host = host_pending;
                if (line_start) begin
                    restart    = 1'b1;
                    state_next = FETCH;
                end
            end

            FETCH: begin
                if (host_slot) begin
                    issue_host = 1'b1;
                end else begin
                    issue_fetch = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_next = DRAIN;
                    end
                end
                // A new line overrides the end-of-line transition.
                if (line_start) begin
                    restart    = 1'b1;
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                issue_host = host_pending;
                if (!fetch_inflight) begin
                    state_next = IDLE;
                end
                if (line_start) begin
                    restart    = 1'b1;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Issue nothing while reset is held.
        if (reset) begin
            issue_fetch = 1'b0;
            issue_host  = 1'b0;
            restart     = 1'b0;
        end
    end

    // Build the tags that advance down the pipeline. A restart discards fetch reads still in flight, and host reads pass through.
    always_comb begin
        tag1_d.valid = issue_fetch || (issue_host && !host_we);
        tag1_d.host  = issue_host;
        tag1_d.idx   = idx_q;
        tag2_d       = tag1_q;
        if (restart) begin
            if (!tag1_d.host) begin
                tag1_d.valid = 1'b0;
            end
            if (!tag2_d.host) begin
                tag2_d.valid = 1'b0;
            end
        end
    end

    // State register, fetch pointer, host bookkeeping and tag pipeline.
    always_ff @(posedge clk_vid) begin
        if (reset) begin
            // NOTE: the tag pipeline is cleared along with the control state, so reads issued before reset can never raise lb_we or host_ack.
            state         <= IDLE;
            base_q        <= '0;
            idx_q         <= '0;
            slot_q        <= '0;
            host_issued_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            overrun_q     <= 1'b0;
            tag1_q        <= '0;
            tag2_q        <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register here sample pre-edge values, so statement order does not matter.
            state <= state_next;

            if (restart) begin
                base_q <= line_base;
                idx_q  <= '0;
                slot_q <= '0;
            end else if (state == FETCH) begin
                slot_q <= (slot_q == SLOT_LAST) ? 3'd0 : slot_q + 3'd1;
                if (issue_fetch) begin
                    idx_q <= idx_q + 8'd1;
                end
            end

            if (host_ack_raw) begin
                host_issued_q <= 1'b0;
            end else if (issue_host) begin
                host_issued_q <= 1'b1;
            end

            wr_ack_q  <= issue_host && host_we;
            overrun_q <= line_start && (state != IDLE);
            tag1_q    <= tag1_d;
            tag2_q    <= tag2_d;
        end
    end

    // Drive the memory port and the return-side outputs. Everything stays low while reset is held.
    always_comb begin
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        host_ack   = 1'b0;
        host_rdata = '0;
        lb_we      = 1'b0;
        lb_addr    = '0;
        lb_data    = '0;
        fetch_busy = 1'b0;

        if (!reset) begin
            if (issue_host) begin
                mem_addr = host_addr;
                mem_rd   = !host_we;
                mem_wr   = host_we;
                if (host_we) begin
                    mem_wdata = host_wdata;
                end
            end else if (issue_fetch) begin
                mem_addr = fetch_addr;
                mem_rd   = 1'b1;
            end

            host_ack = host_ack_raw;
            if (rd_ack) begin
                host_rdata = mem_rdata;
            end

            if (tag2_q.valid && !tag2_q.host) begin
                lb_we   = 1'b1;
                lb_addr = tag2_q.idx;
                lb_data = mem_rdata;
            end

            fetch_busy = (state != IDLE);
        end
    end

endmodule

// File: tb/tb_vid_fetch_arbiter.sv
// tb_vid_fetch_arbiter
// Directed bench for vid_fetch_arbiter with default parameters. A small
// memory model returns a fixed byte pattern of the address two cycles after
// each read. A line-buffer monitor checks every lb write against the
// expected index and the pattern data.
module tb_vid_fetch_arbiter;

    localparam int LB = 160;

    logic        clk_vid = 1'b0;
    logic        reset;
    logic        line_start;
    logic [16:0] line_base;
    logic        host_req;
    logic        host_we;
    logic [16:0] host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic [7:0]  host_rdata;
    logic [16:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        lb_we;
    logic [7:0]  lb_addr;
    logic [7:0]  lb_data;
    logic        fetch_busy;
    logic        overrun;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_vid = ~clk_vid;

    vid_fetch_arbiter #(
        .LINE_BYTES (160),
        .HOST_PERIOD(4)
    ) dut (
        .clk_vid   (clk_vid),
        .reset     (reset),
        .line_start(line_start),
        .line_base (line_base),
        .host_req  (host_req),
        .host_we   (host_we),
        .host_addr (host_addr),
        .host_wdata(host_wdata),
        .host_ack  (host_ack),
        .host_rdata(host_rdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .lb_we     (lb_we),
        .lb_addr   (lb_addr),
        .lb_data   (lb_data),
        .fetch_busy(fetch_busy),
        .overrun   (overrun)
    );

    // Byte pattern that the memory model stores at each address.
    function automatic logic [7:0] mem_pattern(input logic [16:0] a);
        return a[7:0] ^ {a[15:9], a[16]} ^ 8'h5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    // Memory model: the read seen mid-cycle returns its data two cycles later.
    logic        s_rd    = 1'b0;
    logic [16:0] s_addr  = '0;
    logic        d1_rd   = 1'b0;
    logic [16:0] d1_addr = '0;
    logic        d2_rd   = 1'b0;
    logic [16:0] d2_addr = '0;

    always @(negedge clk_vid) begin
        s_rd   = mem_rd;
        s_addr = mem_addr;
    end

    always @(posedge clk_vid) begin
        d1_rd   <= s_rd;
        d1_addr <= s_addr;
        d2_rd   <= d1_rd;
        d2_addr <= d1_addr;
    end

    assign mem_rdata = d2_rd ? mem_pattern(d2_addr) : 8'h00;

    // Line-buffer monitor and mem_rd/mem_wr exclusivity.
    logic        mon_en   = 1'b0;
    logic [16:0] mon_base = '0;
    int          mon_idx  = 0;

    always @(negedge clk_vid) begin
        logic [16:0] ma;
        if (lb_we) begin
            if (!mon_en) begin
                check("lb_we_unexpected", lb_we, 1'b0);
            end else begin
                ma = mon_base + 17'(mon_idx);
                check("lb_addr", lb_addr, mon_idx[7:0]);
                check("lb_data", lb_data, mem_pattern(ma));
                mon_idx++;
            end
        end
        if (!reset) begin
            check("rd_wr_excl", mem_rd & mem_wr, 1'b0);
        end
    end

    task automatic next_cycle();
        @(posedge clk_vid);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_host_ack"},   host_ack,   1'b0);
        check({tag, "_host_rdata"}, host_rdata, 8'h00);
        check({tag, "_mem_addr"},   mem_addr,   17'h0);
        check({tag, "_mem_rd"},     mem_rd,     1'b0);
        check({tag, "_mem_wr"},     mem_wr,     1'b0);
        check({tag, "_mem_wdata"},  mem_wdata,  8'h00);
        check({tag, "_lb_we"},      lb_we,      1'b0);
        check({tag, "_lb_addr"},    lb_addr,    8'h00);
        check({tag, "_lb_data"},    lb_data,    8'h00);
        check({tag, "_busy"},       fetch_busy, 1'b0);
        check({tag, "_overrun"},    overrun,    1'b0);
    endtask

    // Wait for the drain after the last issue: busy through the return cycle, low after.
    task automatic drain_and_check(input string tag);
        next_cycle(); settle();
        check({tag, "_drain_rd"},    mem_rd,     1'b0);
        check({tag, "_drain_busy1"}, fetch_busy, 1'b1);
        next_cycle(); settle();
        check({tag, "_drain_busy2"}, fetch_busy, 1'b1);
        next_cycle(); settle();
        check({tag, "_idle_busy"},   fetch_busy, 1'b0);
        check({tag, "_lb_count"},    mon_idx,    LB);
        mon_en = 1'b0;
    endtask

    // Fetch one whole line with no host traffic.
    task automatic plain_line(input logic [16:0] base, input string tag);
        logic [16:0] ea;
        next_cycle();
        line_start = 1'b1;
        line_base  = base;
        settle();
        check({tag, "_start_busy"}, fetch_busy, 1'b0);
        check({tag, "_start_rd"},   mem_rd,     1'b0);
        mon_en   = 1'b1;
        mon_base = base;
        mon_idx  = 0;
        for (int k = 0; k < LB; k++) begin
            next_cycle();
            line_start = 1'b0;
            settle();
            ea = base + 17'(k);
            check({tag, "_rd"},   mem_rd,     1'b1);
            check({tag, "_addr"}, mem_addr,   ea);
            check({tag, "_busy"}, fetch_busy, 1'b1);
            if (ea == 17'h0) begin
                check({tag, "_wrap_zero"}, mem_addr, 17'h0);
            end
        end
        drain_and_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] ea;
        reset      = 1'b1;
        line_start = 1'b0;
        line_base  = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;

        // Reset state.
        next_cycle();
        next_cycle();
        settle();
        check_all_zero("reset");
        next_cycle();
        reset = 1'b0;
        settle();
        check("idle_rd",   mem_rd,     1'b0);
        check("idle_busy", fetch_busy, 1'b0);

        // Plain line, then a line that wraps past the top of the address space.
        plain_line(17'h1F000, "line");
        plain_line(17'h1FFF0, "wrap");

        // Host read held across a fetch goes out in the first slot with counter 3.
        next_cycle();
        line_start = 1'b1;
        line_base  = 17'h00100;
        settle();
        mon_en   = 1'b1;
        mon_base = 17'h00100;
        mon_idx  = 0;
        for (int k = 0; k <= LB; k++) begin
            next_cycle();
            line_start = 1'b0;
            if (k == 0) begin
                host_req  = 1'b1;
                host_we   = 1'b0;
                host_addr = 17'h00400;
            end
            if (k == 6) begin
                host_req = 1'b0;
            end
            settle();
            if (k == 3) ea = 17'h00400;
            else if (k < 3) ea = 17'h00100 + 17'(k);
            else ea = 17'h00100 + 17'(k - 1);
            check("hrd_rd",   mem_rd,   1'b1);
            check("hrd_addr", mem_addr, ea);
            check("hrd_ack",  host_ack, (k == 5));
            if (k == 5) begin
                check("hrd_rdata", host_rdata, mem_pattern(17'h00400));
            end
        end
        drain_and_check("hrd");

        // Host write in IDLE: issue at once, ack next cycle, no reissue while still held.
        next_cycle();
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 17'h00010;
        host_wdata = 8'hA5;
        settle();
        check("hwr_wr",    mem_wr,    1'b1);
        check("hwr_rd",    mem_rd,    1'b0);
        check("hwr_addr",  mem_addr,  17'h00010);
        check("hwr_wdata", mem_wdata, 8'hA5);
        check("hwr_ack0",  host_ack,  1'b0);
        next_cycle();
        settle();
        check("hwr_ack1",    host_ack, 1'b1);
        check("hwr_no_reis", mem_wr,   1'b0);
        next_cycle();
        host_req = 1'b0;
        host_we  = 1'b0;
        settle();
        check("hwr_ack2", host_ack, 1'b0);
        check("hwr_wr2",  mem_wr,   1'b0);

        // line_start together with a host read in IDLE, then an overrun at index 50.
        next_cycle();
        line_start = 1'b1;
        line_base  = 17'h00200;
        host_req   = 1'b1;
        host_we    = 1'b0;
        host_addr  = 17'h00020;
        settle();
        check("co_rd",   mem_rd,     1'b1);
        check("co_addr", mem_addr,   17'h00020);
        check("co_busy", fetch_busy, 1'b0);
        mon_en   = 1'b1;
        mon_base = 17'h00200;
        mon_idx  = 0;
        for (int k = 0; k <= 50; k++) begin
            next_cycle();
            line_start = (k == 50);
            if (k == 50) line_base = 17'h00800;
            if (k == 2) host_req = 1'b0;
            settle();
            ea = 17'h00200 + 17'(k);
            check("co_fetch_rd",   mem_rd,   1'b1);
            check("co_fetch_addr", mem_addr, ea);
            check("co_ack",        host_ack, (k == 1));
            check("co_overrun",    overrun,  1'b0);
            if (k == 1) begin
                check("co_rdata", host_rdata, mem_pattern(17'h00020));
            end
        end
        for (int k = 0; k < LB; k++) begin
            next_cycle();
            if (k == 0) begin
                check("ovr_old_count", mon_idx, 49);
                mon_base = 17'h00800;
                mon_idx  = 0;
            end
            line_start = 1'b0;
            settle();
            ea = 17'h00800 + 17'(k);
            check("ovr_rd",      mem_rd,   1'b1);
            check("ovr_addr",    mem_addr, ea);
            check("ovr_overrun", overrun,  (k == 0));
            if (k < 2) begin
                check("ovr_discard", lb_we, 1'b0);
            end
        end
        drain_and_check("ovr");

        // Reset at fetch index 20 while a host read is still in flight.
        next_cycle();
        line_start = 1'b1;
        line_base  = 17'h00000;
        settle();
        mon_en   = 1'b1;
        mon_base = 17'h00000;
        mon_idx  = 0;
        for (int k = 0; k <= 20; k++) begin
            next_cycle();
            line_start = 1'b0;
            if (k == 16) begin
                host_req  = 1'b1;
                host_we   = 1'b0;
                host_addr = 17'h00400;
            end
            settle();
            if (k == 19) ea = 17'h00400;
            else if (k < 19) ea = 17'(k);
            else ea = 17'(k - 1);
            check("rst_pre_rd",   mem_rd,   1'b1);
            check("rst_pre_addr", mem_addr, ea);
        end
        next_cycle();
        reset    = 1'b1;
        host_req = 1'b0;
        check("rst_lb_count", mon_idx, 19);
        mon_en = 1'b0;
        settle();
        check("rst_cyc_ack", host_ack, 1'b0);
        check("rst_cyc_lb",  lb_we,    1'b0);
        check("rst_cyc_rd",  mem_rd,   1'b0);
        next_cycle();
        settle();
        check_all_zero("rst_held");
        next_cycle();
        reset = 1'b0;
        settle();
        check_all_zero("rst_rel");
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            settle();
            check("rst_after_ack",  host_ack,   1'b0);
            check("rst_after_lb",   lb_we,      1'b0);
            check("rst_after_busy", fetch_busy, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
